// File: rtl/conv_writeback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_writeback_sequencer
//  Brief    : Streams input/weight scratchpad vectors into the XNOR
//             accelerator and writes each latency-aligned result into the
//             output scratchpad, under a start/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_writeback_sequencer #(
  parameter int NUMHELPER       = 4,
  parameter int INPUT_BITWIDTH  = 25,
  parameter int OUTPUT_BITWIDTH = 6,
  parameter int SIZE            = 16,
  parameter int SPAD_LATENCY    = 1,
  parameter int ACC_LATENCY     = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(SIZE):0]                length,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 in_on,
  output logic                                 wt_on,
  output logic [$clog2(SIZE)-1:0]              in_addr,
  output logic [$clog2(SIZE)-1:0]              wt_addr,
  output logic                                 acc_reset,
  input  logic [NUMHELPER*OUTPUT_BITWIDTH-1:0] acc_out_c,
  output logic                                 out_on,
  output logic                                 out_write_enable,
  output logic [$clog2(SIZE)-1:0]              out_addr,
  output logic [NUMHELPER*INPUT_BITWIDTH-1:0]  out_data_in
);

  localparam int c_AW = $clog2(SIZE);
  localparam int c_CW = c_AW + 1;
  localparam int c_L  = SPAD_LATENCY + ACC_LATENCY;
  localparam int c_DW = NUMHELPER * INPUT_BITWIDTH;

  localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
  localparam logic [c_CW-1:0] c_ZERO   = '0;
  localparam logic [c_CW-1:0] c_SIZE_W = c_CW'(SIZE);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [c_CW-1:0] len_q;
  logic [c_CW-1:0] issue_cnt_q;
  logic [c_CW-1:0] wb_cnt_q;
  logic [c_L-1:0]  valid_q;

  logic [c_CW-1:0] w_len_clamped;
  logic            w_accept;
  logic            w_issue;
  logic            w_wb;
  logic            w_last_issue;
  logic            w_wb_last;

  // Lengths above the scratchpad depth are treated as a full-depth run.
  assign w_len_clamped = (length > c_SIZE_W) ? c_SIZE_W : length;
  assign w_accept      = (state_q == c_S_IDLE) && start;
  assign w_issue       = (state_q == c_S_ISSUE);
  assign w_wb          = valid_q[c_L-1];
  assign w_last_issue  = w_issue && (issue_cnt_q == len_q - c_ONE);
  // Leave DRAIN in the cycle that performs the final write so done lands at N+L.
  assign w_wb_last     = w_wb && ((wb_cnt_q + c_ONE) == len_q);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= c_S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE:  if (start) state_d = (w_len_clamped == c_ZERO) ? c_S_DONE : c_S_ISSUE;
      c_S_ISSUE: if (w_last_issue) state_d = c_S_DRAIN;
      c_S_DRAIN: if (w_wb_last) state_d = c_S_DONE;
      c_S_DONE:  state_d = c_S_IDLE;
      default:   state_d = c_S_IDLE;
    endcase
  end

  // Output decode: read side from the state, write side from the valid-pipeline tail.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    in_on            = 1'b0;
    wt_on            = 1'b0;
    in_addr          = '0;
    wt_addr          = '0;
    acc_reset        = 1'b1;
    out_on           = 1'b0;
    out_write_enable = 1'b0;
    out_addr         = '0;
    out_data_in      = '0;
    case (state_q)
      c_S_ISSUE: begin
        busy      = 1'b1;
        acc_reset = 1'b0;
        in_on     = 1'b1;
        wt_on     = 1'b1;
        in_addr   = issue_cnt_q[c_AW-1:0];
        wt_addr   = issue_cnt_q[c_AW-1:0];
      end
      c_S_DRAIN: begin
        busy      = 1'b1;
        acc_reset = 1'b0;
      end
      c_S_DONE:  done = 1'b1;
      default: ;
    endcase
    if (w_wb) begin
      out_on           = 1'b1;
      out_write_enable = 1'b1;
      out_addr         = wb_cnt_q[c_AW-1:0];
      out_data_in      = c_DW'(acc_out_c);
    end
  end

  // Run length latch plus issue and writeback counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q       <= '0;
      issue_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      if (w_accept) begin
        len_q       <= w_len_clamped;
        issue_cnt_q <= '0;
        wb_cnt_q    <= '0;
      end else begin
        if (w_issue) issue_cnt_q <= issue_cnt_q + c_ONE;
        if (w_wb)    wb_cnt_q    <= wb_cnt_q + c_ONE;
      end
    end
  end

  generate
    if (c_L == 1) begin : g_vpipe_single
      // One-stage valid pipeline: a result follows its read by one cycle.
      always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else       valid_q <= w_issue;
      end
    end else begin : g_vpipe_multi
      // Valid tokens ride alongside the scratchpad and accelerator latency.
      always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else       valid_q <= {valid_q[c_L-2:0], w_issue};
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_writeback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_writeback_sequencer
//  Brief    : Self-checking bench with scratchpad/accelerator environment
//             models and an XNOR-popcount reference for the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_writeback_sequencer;

  localparam int NH   = 4;
  localparam int IW   = 25;
  localparam int OW   = 6;
  localparam int SIZE = 16;
  localparam int AW   = 4;
  localparam int CW   = 5;
  localparam int L    = 2;
  localparam int DW   = NH * IW;
  localparam int RW   = NH * OW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] length;
  logic          busy, done, in_on, wt_on, acc_reset, out_on, out_we;
  logic [AW-1:0] in_addr, wt_addr, out_addr;
  logic [RW-1:0] acc_out_c;
  logic [DW-1:0] out_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  conv_writeback_sequencer #(
    .NUMHELPER(NH), .INPUT_BITWIDTH(IW), .OUTPUT_BITWIDTH(OW),
    .SIZE(SIZE), .SPAD_LATENCY(1), .ACC_LATENCY(1)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .busy(busy), .done(done), .in_on(in_on), .wt_on(wt_on),
    .in_addr(in_addr), .wt_addr(wt_addr), .acc_reset(acc_reset),
    .acc_out_c(acc_out_c), .out_on(out_on), .out_write_enable(out_we),
    .out_addr(out_addr), .out_data_in(out_data_in)
  );

  always #5 clock = ~clock;

  // Environment: input/weight scratchpads (1-cycle read) and accelerator (1-cycle).
  logic [DW-1:0] in_mem [SIZE];
  logic [DW-1:0] wt_mem [SIZE];
  logic [DW-1:0] in_dout, wt_dout;

  always @(posedge clock) begin
    if (in_on) in_dout <= in_mem[in_addr];
    if (wt_on) wt_dout <= wt_mem[wt_addr];
  end

  always @(posedge clock) begin
    if (acc_reset) acc_out_c <= '0;
    else
      for (int j = 0; j < NH; j++)
        acc_out_c[j*OW +: OW] <= OW'(2 * $countones(~(in_dout[j*IW +: IW] ^ wt_dout[j*IW +: IW])) - IW);
  end

  // Reference: per lane, each bit contributes +1 on match and -1 on mismatch.
  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < NH; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < IW; i++) s += (a[j*IW+i] == b[j*IW+i]) ? 1 : -1;
      r[j*OW +: OW] = OW'(s);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_on"}, in_on, 0);
    chk({tag, "_wt_on"}, wt_on, 0);
    chk({tag, "_out_on"}, out_on, 0);
    chk({tag, "_out_we"}, out_we, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_wt_addr"}, wt_addr, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data_in, 0);
    chk({tag, "_acc_reset"}, acc_reset, 1);
  endtask

  task automatic fill_random();
    for (int k = 0; k < SIZE; k++)
      for (int j = 0; j < NH; j++) begin
        in_mem[k][j*IW +: IW] = IW'($urandom);
        wt_mem[k][j*IW +: IW] = IW'($urandom);
      end
  endtask

  logic [DW-1:0] got_w [SIZE];

  // One run: accept at the current negedge, then watch cycles 0..n+L+4.
  // pmask bit c pulses start (with a different length) during cycle c.
  // rst_at >= 0 asserts reset during that cycle.
  task automatic run(input string tag, input int len_drv, input int n,
                     input logic [31:0] pmask, input int rst_at);
    logic [DW-1:0] expw [SIZE];
    int wb, rd, dones, done_c, late_wr, hi_wr;
    for (int k = 0; k < SIZE; k++) begin
      expw[k]  = ref_word(in_mem[k], wt_mem[k]);
      got_w[k] = '0;
    end
    wb = 0; rd = 0; dones = 0; done_c = -1; late_wr = 0; hi_wr = 0;
    start  = 1'b1;
    length = CW'(len_drv);
    @(negedge clock);
    for (int c = 0; c < n + L + 5; c++) begin
      start  = pmask[c];
      length = pmask[c] ? CW'(3) : CW'(len_drv);
      if (c == rst_at) reset = 1'b1;
      if (rst_at >= 0 && c == rst_at + 1) begin
        reset = 1'b0;
        chk_reset_outputs({tag, "_postrst"});
      end
      if (in_on) begin
        chk({tag, "_rd_addr"}, in_addr, c);
        chk({tag, "_wt_addr"}, wt_addr, c);
        chk({tag, "_rd_in_range"}, (c < n), 1);
        rd++;
      end
      if (out_on && out_we) begin
        if (rst_at >= 0 && c > rst_at) late_wr++;
        if (out_addr >= 4) hi_wr++;
        if (wb < SIZE) begin
          chk({tag, "_wr_addr"}, out_addr, wb);
          chk({tag, "_wr_data"}, out_data_in, expw[wb]);
          chk({tag, "_wr_cycle"}, c, wb + L);
          got_w[wb] = out_data_in;
        end
        wb++;
      end
      if (done) begin
        dones++;
        if (done_c < 0) done_c = c;
        chk({tag, "_busy_at_done"}, busy, 0);
      end
      @(negedge clock);
    end
    if (rst_at < 0) begin
      chk({tag, "_done_count"}, dones, 1);
      chk({tag, "_done_cycle"}, done_c, (n == 0) ? 0 : n + L);
      chk({tag, "_writes"}, wb, n);
      chk({tag, "_reads"}, rd, n);
    end else begin
      chk({tag, "_done_count"}, dones, 0);
      chk({tag, "_late_writes"}, late_wr, 0);
      chk({tag, "_hi_addr_writes"}, hi_wr, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    length = '0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Known values, N=3.
    fill_random();
    in_mem[0] = '1; wt_mem[0] = '1;
    in_mem[1] = '1; wt_mem[1] = '0;
    in_mem[2] = '1;
    for (int j = 0; j < NH; j++) wt_mem[2][j*IW +: IW] = IW'(25'h0000FFF);
    run("known", 3, 3, 32'h0, -1);
    chk("known_w0", got_w[0], DW'({NH{6'b011001}}));
    chk("known_w1", got_w[1], DW'({NH{6'b100111}}));
    chk("known_w2", got_w[2], DW'({NH{6'b111111}}));
    repeat (2) @(negedge clock);

    // Full depth, random data.
    fill_random();
    run("full", 16, 16, 32'h0, -1);
    repeat (2) @(negedge clock);

    // Zero-length run.
    run("zero", 0, 0, 32'h0, -1);
    repeat (2) @(negedge clock);

    // Start pulses in ISSUE (2), DRAIN (7) and DONE (8) of an N=6 run.
    fill_random();
    run("busy_start", 6, 6, (32'h1 << 2) | (32'h1 << 7) | (32'h1 << 8), -1);
    repeat (2) @(negedge clock);

    // Reset in cycle 5 of an N=16 run, then a fresh N=4 run.
    fill_random();
    run("midrst", 16, 16, 32'h0, 5);
    repeat (2) @(negedge clock);
    fill_random();
    run("after_rst", 4, 4, 32'h0, -1);
    repeat (2) @(negedge clock);

    // Length clamp: SIZE+1 behaves as SIZE.
    fill_random();
    run("clamp", SIZE + 1, SIZE, 32'h0, -1);
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_writeback_sequencer.md
# conv_writeback_sequencer

Autonomous sequencer for the XNOR convolution datapath. It streams vectors out of the input and weight scratchpads in lockstep and feeds them to the `XNORconvBlackBox` accelerator. It then writes each accelerator result, aligned to the pipeline latency, into the output scratchpad, so no testbench or host has to drive scratchpad addresses cycle by cycle. It sits between the three `scratchpad` instances and the accelerator, and is controlled by a start/done handshake.

## Interface
Parameters:
- `NUMHELPER`, 4, number of XNOR lanes
- `INPUT_BITWIDTH`, 25, bits per lane in input/weight words
- `OUTPUT_BITWIDTH`, 6, signed result bits per lane
- `SIZE`, 16, scratchpad depth in words
- `SPAD_LATENCY`, 1, cycles from scratchpad address/on to `data_out`
- `ACC_LATENCY`, 1, cycles from accelerator `pe_in_*` to `pe_out_c`

Ports:
- `clock`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `length`  in  $clog2(SIZE)+1  number of vectors N (0..SIZE); values >SIZE clamp to SIZE
- `busy`  out  1  high in ISSUE and DRAIN
- `done`  out  1  one-cycle pulse in DONE
- `in_on`, `wt_on`  out  1  enables for the input and weight scratchpads
- `in_addr`, `wt_addr`  out  $clog2(SIZE)  read addresses; always equal
- `acc_reset`  out  1  reset for the accelerator
- `acc_out_c`  in  NUMHELPER*OUTPUT_BITWIDTH  accelerator `pe_out_c`
- `out_on`, `out_write_enable`  out  1  controls for the output scratchpad
- `out_addr`  out  $clog2(SIZE)  write address
- `out_data_in`  out  NUMHELPER*INPUT_BITWIDTH  `acc_out_c` in the low bits, upper bits zero

## Operation
- States:
  - IDLE → ISSUE on `start` with N>0.
  - IDLE → DONE on `start` with N=0.
  - ISSUE → DRAIN after N issue cycles.
  - DRAIN → DONE when the writeback count equals N.
  - DONE → IDLE unconditionally.
- ISSUE:
  - `in_on`=`wt_on`=1, with `in_addr`=`wt_addr`=issue count, 0..N-1, incrementing every cycle.
  - A valid token enters an L=SPAD_LATENCY+ACC_LATENCY-deep valid shift register each cycle.
- Writeback:
  - Active in any cycle where the shift-register tail is valid.
  - `out_on`=`out_write_enable`=1, `out_addr`=writeback count, `out_data_in`=zero-extended `acc_out_c`, passed combinationally from the current cycle.
  - The writeback count then increments.
- Issue and writeback overlap: ISSUE continues issuing while early results are written.
- Counters are $clog2(SIZE)+1 bits wide. N=SIZE issues addresses 0..SIZE-1 with no wrap, and addresses never exceed N-1.
- `acc_reset`=1 in IDLE and DONE, 0 in ISSUE and DRAIN.
- `start` is ignored outside IDLE, including in the DONE cycle; `length` is latched at accept.
- `reset` at any time, including mid-run:
  - all state returns to IDLE and the valid pipeline is flushed;
  - no further output writes occur;
  - no `done` pulse is produced.
- Reset values of outputs:
  - `busy`=0, `done`=0;
  - `in_on`=`wt_on`=`out_on`=`out_write_enable`=0;
  - all addresses 0, `out_data_in`=0;
  - `acc_reset`=1.

## Timing
- Cycle numbering is relative to the first ISSUE cycle (cycle 0); `start` is sampled at the edge ending the last IDLE cycle.
- Read of vector k is issued in cycle k, for k = 0..N-1.
- Scratchpad data for vector k is valid in cycle k+SPAD_LATENCY.
- The result for vector k is written during cycle k+L, captured at that cycle's closing edge.
- With the defaults (L=2), writes occur in cycles 2..N+1.
- `done` is asserted in cycle N+L and `busy` falls in the same cycle; the earliest next `start` is accepted in cycle N+L+1.
- For N=0, `done` is asserted in the cycle after `start` is accepted, with no reads or writes.
- Throughput is one vector per cycle with no bubbles.

## Test plan
- **Known values, N=3:**
  - Stimulus:
    - Address 0: input all-ones, weight all-ones.
    - Address 1: input all-ones, weight all-zeros.
    - Address 2: lane j with 12 matching bits.
  - Required response:
    - Output address 0 = lanes 6'b011001 (+25).
    - Output address 1 = lanes 6'b100111 (-25).
    - Output address 2 = lanes 6'b111111 (-1).
    - `done` in cycle 5.
- **Full depth, N=16, random data:**
  - Every output word matches the reference XNOR-popcount (±1 per bit) for each lane.
  - Exactly 16 writes, at addresses 0..15 in order.
  - `done` in cycle 18; `in_addr` never exceeds 15.
- **N=0:** `done` pulses one cycle after `start`; no `in_on` and no `out_write_enable` ever asserted.
- **Start while busy:**
  - Stimulus: pulse `start` during ISSUE, DRAIN and DONE.
  - Required response: no restart; writeback count and addresses unaffected; exactly one `done`.
- **Reset mid-run:**
  - Stimulus: assert `reset` in cycle 5 of an N=16 run.
  - Required response: all outputs hold their reset values the next cycle; no writes after that; output scratchpad words 4..15 unchanged.
  - Follow-up: a new N=4 run afterwards completes correctly.
- **Length clamp:** `length`=SIZE+1 behaves identically to N=SIZE.
